div_request_scheduler: RTL and testbench
========================================

# div_request_scheduler

Shares one sequential signed divider (load/shift/subshift datapath plus its N-cycle controller) among R independent requesters. Each requester presents dividend/divisor via valid/ready. The block arbitrates round-robin, issues a one-cycle start to the divider, waits for completion, and returns quotient and remainder tagged with the requester index. It sits between the CPU's multi-issue/execute ports and the single shared divider instance.

## Interface
Parameters:
- N, 8: dividend/quotient width; also the divider iteration count.
- M, 4: divisor/remainder width.
- R, 4: number of requesters (2..16).
- IDW, $clog2(R): requester-ID width (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- req_valid  in  R  per-requester request valid.
- req_ready  out  R  one-hot accept pulse.
- req_dividend  in  R*N  packed dividends; requester i at [i*N +: N].
- req_divisor  in  R*M  packed divisors; requester i at [i*M +: M].
- div_start  out  1  start pulse to the divider controller.
- div_dividend  out  N  latched dividend to the divider datapath.
- div_divisor  out  M  latched divisor to the divider datapath.
- div_ready  in  1  divider idle (high in S0, low while iterating or in reset).
- div_quotient  in  N  divider quotient.
- div_remainder  in  M  divider remainder.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  IDW  index of the served requester.
- rsp_quotient  out  N  registered quotient.
- rsp_remainder  out  M  registered remainder.
- rsp_divzero  out  1  divide-by-zero flag.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid and div_ready, grant = first asserted index at or above rr_ptr, wrapping. Assert req_ready[grant] combinationally in that cycle. Latch operands and ID. Set rr_ptr <= (grant+1) mod R. Go to ISSUE.
- ISSUE: div_start=1 for exactly one cycle. Go to WAIT.
- WAIT: stay while div_ready=0. On the first cycle with div_ready=1, register div_quotient/div_remainder into rsp_* and go to RESP.
- RESP: rsp_valid=1, outputs held stable until rsp_ready. When rsp_valid && rsp_ready, go to IDLE.
- No request is accepted while the block is not in IDLE. req_ready is 0 outside IDLE.
- Requests not granted stay pending. A requester dropping req_valid before grant is legal.
- Operands are forwarded bit-exact. Signedness is handled entirely by the divider.
- Reset, including mid-operation: state IDLE, rr_ptr 0. All outputs 0: req_ready, div_start, div_dividend, div_divisor, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_divzero. The divider shares the same reset.

## Timing
- Accept in cycle a. div_start at a+1. div_ready is low a+2..a+N+1 and high at a+N+2, where the result is captured. rsp_valid is first high at a+N+3.
- Back-to-back: the earliest next accept is the cycle after the rsp handshake.
- rsp_ready held high: rsp_valid lasts 1 cycle. Throughput is one operation per N+4 cycles.
- The grant decision uses registered rr_ptr only. There is no combinational path from rsp_ready to req_ready.

## Configuration
- DIV_SCHED_DIVZERO_EN defined:
  - At accept, a divisor of 0 bypasses the divider and goes IDLE -> RESP directly, so rsp_valid is at a+1.
  - The response is rsp_quotient = all ones, rsp_remainder = dividend[M-1:0], rsp_divzero = 1.
  - div_start is not asserted for that request.
- DIV_SCHED_DIVZERO_EN undefined: zero divisors go through the divider normally, and rsp_divzero is tied 0.

## Structure
- Package div_sched_pkg: FSM state enum (2-bit), state encodings, divide-by-zero quotient constant function.
- Sub-module rr_arbiter: parameter R; inputs req[R], ptr[IDW]; outputs one-hot grant[R], grant_idx[IDW], any. Purely combinational.
- The top module holds the FSM, operand/ID/response registers and rr_ptr.

## Test plan
- Single request: R=4, N=8. Requester 2 sends dividend 100, divisor 7. Expect rsp_id=2, quotient 14, remainder 2, rsp_valid exactly at a+11.
- Fairness: all four req_valid held high, rsp_ready=1. Grants must be 0,1,2,3,0, each operation N+4 cycles apart.
- Backpressure: hold rsp_ready=0 for 20 cycles. rsp_valid and rsp_* stay stable, req_ready stays 0. Release, then the next grant occurs the cycle after the handshake.
- Reset mid-WAIT: assert reset 3 cycles after div_start. All outputs are 0 and the state is IDLE. After release, a new request completes correctly and grant starts from index 0.
- Divide-by-zero with the macro: dividend 0x5A, divisor 0. Expect rsp_valid at a+1, quotient 0xFF, remainder 0xA, rsp_divzero=1, no div_start. Without the macro: div_start is issued and rsp_divzero=0.
- Signed operands: dividend -100 (0x9C), divisor 7. The response equals the divider outputs bit-exact, checked against the divider model.

Source files
------------

// File: rtl/div_sched_pkg.sv
// ============================================================================
// Module      : div_sched_pkg
// Description : Shared types and constants for the divider request scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_t;

    // Quotient returned for a zero divisor; callers slice it to their width.
    function automatic logic [31:0] divzero_quotient();
        return '1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker: first request at or above ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int R   = 4,
    parameter int IDW = $clog2(R)
) (
    input  logic [R-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [R-1:0]   grant,
    output logic [IDW-1:0] grant_idx,
    output logic           any
);

    always_comb begin
        int j;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        j         = 0;
        for (int k = 0; k < R; k++) begin
            j = int'(ptr) + k;
            if (j >= R) begin
                j = j - R;
            end
            if (!any && req[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDW'(j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/div_request_scheduler.sv
// ============================================================================
// Module      : div_request_scheduler
// Description : Round-robin sharing of one sequential divider among R clients.
//               Optional macro DIV_SCHED_DIVZERO_EN: zero divisors bypass
//               the divider and answer directly with a divide-by-zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_request_scheduler
    import div_sched_pkg::*;
#(
    parameter int N   = 8,
    parameter int M   = 4,
    parameter int R   = 4,
    parameter int IDW = $clog2(R)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [R-1:0]   req_valid,
    output logic [R-1:0]   req_ready,
    input  logic [R*N-1:0] req_dividend,
    input  logic [R*M-1:0] req_divisor,
    output logic           div_start,
    output logic [N-1:0]   div_dividend,
    output logic [M-1:0]   div_divisor,
    input  logic           div_ready,
    input  logic [N-1:0]   div_quotient,
    input  logic [M-1:0]   div_remainder,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [IDW-1:0] rsp_id,
    output logic [N-1:0]   rsp_quotient,
    output logic [M-1:0]   rsp_remainder,
    output logic           rsp_divzero
);

    localparam logic [31:0] DZ_QUOT_FULL = divzero_quotient();

    sched_state_t   state_q;
    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] rr_ptr_d;
    logic           div_start_q;
    logic [N-1:0]   div_dividend_q;
    logic [M-1:0]   div_divisor_q;
    logic           rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;
    logic [N-1:0]   rsp_quotient_q;
    logic [M-1:0]   rsp_remainder_q;
    logic           rsp_divzero_q;

    logic [R-1:0]   w_grant;
    logic [IDW-1:0] w_grant_idx;
    logic           w_any;
    logic           w_accept;
    logic           w_dz;
    logic [N-1:0]   w_dividend;
    logic [M-1:0]   w_divisor;

    rr_arbiter #(
        .R   (R),
        .IDW (IDW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .any       (w_any)
    );

    // Accept depends only on registered state and the request/idle inputs.
    assign w_accept  = (state_q == ST_IDLE) && div_ready && w_any && !reset;
    assign req_ready = w_accept ? w_grant : '0;
    assign rr_ptr_d  = (w_grant_idx == IDW'(R - 1)) ? '0 : w_grant_idx + IDW'(1);

    always_comb begin
        w_dividend = '0;
        w_divisor  = '0;
        for (int i = 0; i < R; i++) begin
            if (w_grant[i]) begin
                w_dividend = w_dividend | req_dividend[i*N +: N];
                w_divisor  = w_divisor  | req_divisor[i*M +: M];
            end
        end
    end

`ifdef DIV_SCHED_DIVZERO_EN
    assign w_dz = (w_divisor == '0);
`else
    assign w_dz = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            rr_ptr_q        <= '0;
            div_start_q     <= 1'b0;
            div_dividend_q  <= '0;
            div_divisor_q   <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_id_q        <= '0;
            rsp_quotient_q  <= '0;
            rsp_remainder_q <= '0;
            rsp_divzero_q   <= 1'b0;
        end else begin
            div_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        div_dividend_q <= w_dividend;
                        div_divisor_q  <= w_divisor;
                        rsp_id_q       <= w_grant_idx;
                        rr_ptr_q       <= rr_ptr_d;
                        if (w_dz) begin
                            rsp_quotient_q  <= DZ_QUOT_FULL[N-1:0];
                            rsp_remainder_q <= w_dividend[M-1:0];
                            rsp_divzero_q   <= 1'b1;
                            rsp_valid_q     <= 1'b1;
                            state_q         <= ST_RESP;
                        end else begin
                            div_start_q <= 1'b1;
                            state_q     <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (div_ready) begin
                        rsp_quotient_q  <= div_quotient;
                        rsp_remainder_q <= div_remainder;
                        rsp_divzero_q   <= 1'b0;
                        rsp_valid_q     <= 1'b1;
                        state_q         <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign div_start     = div_start_q;
    assign div_dividend  = div_dividend_q;
    assign div_divisor   = div_divisor_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_quotient  = rsp_quotient_q;
    assign rsp_remainder = rsp_remainder_q;
    assign rsp_divzero   = rsp_divzero_q;

endmodule

`default_nettype wire

// File: tb/tb_div_request_scheduler.sv
// ============================================================================
// Module      : tb_div_request_scheduler
// Description : Scoreboard bench for div_request_scheduler with a divider model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_request_scheduler;
    import div_sched_pkg::*;

    localparam int N   = 8;
    localparam int M   = 4;
    localparam int R   = 4;
    localparam int IDW = 2;
`ifdef DIV_SCHED_DIVZERO_EN
    localparam bit DZ_EN     = 1'b1;
    localparam int DZ_LAT    = 1;
    localparam int DZ_STARTS = 0;
`else
    localparam bit DZ_EN     = 1'b0;
    localparam int DZ_LAT    = N + 3;
    localparam int DZ_STARTS = 1;
`endif

    logic           clk;
    logic           reset;
    logic [R-1:0]   req_valid;
    logic [R-1:0]   req_ready;
    logic [R*N-1:0] req_dividend;
    logic [R*M-1:0] req_divisor;
    logic           div_start;
    logic [N-1:0]   div_dividend;
    logic [M-1:0]   div_divisor;
    logic           div_ready;
    logic [N-1:0]   div_quotient;
    logic [M-1:0]   div_remainder;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [N-1:0]   rsp_quotient;
    logic [M-1:0]   rsp_remainder;
    logic           rsp_divzero;

    div_request_scheduler #(.N(N), .M(M), .R(R), .IDW(IDW)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_ready     (div_ready),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_divzero   (rsp_divzero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Truncating signed division; zero divisor yields all-ones / low dividend bits.
    function automatic logic [N+M-1:0] ref_div(input logic [N-1:0] a, input logic [M-1:0] b);
        int ia, ib, iq, ir;
        logic [N-1:0] q;
        logic [M-1:0] r;
        if (b == '0) begin
            q = '1;
            r = a[M-1:0];
        end else begin
            ia = int'($signed(a));
            ib = int'($signed(b));
            iq = ia / ib;
            ir = ia % ib;
            q  = iq[N-1:0];
            r  = ir[M-1:0];
        end
        return {q, r};
    endfunction

    // Sequential divider model: busy for N cycles after the start pulse.
    int           m_cnt;
    logic [N-1:0] m_q;
    logic [M-1:0] m_r;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt <= 0;
            m_q   <= '0;
            m_r   <= '0;
        end else if (div_start) begin
            m_cnt      <= N;
            {m_q, m_r} <= ref_div(div_dividend, div_divisor);
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end
    end
    assign div_ready     = !reset && (m_cnt == 0);
    assign div_quotient  = m_q;
    assign div_remainder = m_r;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [IDW-1:0] id;
        logic [N-1:0]   q;
        logic [M-1:0]   r;
        logic           dz;
    } exp_t;
    exp_t sb[$];

    int tb_ptr = 0;
    int n_acc = 0, n_rise = 0, n_hs = 0, n_start = 0;
    int acc_cyc = 0, acc_id = 0, rise_cyc = 0, hs_cyc = 0;
    logic prev_rv = 1'b0;

    always @(negedge clk) begin
        int           g;
        logic [R-1:0] exp_oh;
        exp_t         e;
        if (reset) begin
            sb.delete();
            tb_ptr  = 0;
            prev_rv = 1'b0;
        end else begin
            if (div_start) n_start++;
            if (|req_ready) begin
                g = -1;
                for (int k = 0; k < R; k++) begin
                    int j;
                    j = (tb_ptr + k) % R;
                    if (g < 0 && req_valid[j]) g = j;
                end
                exp_oh = (g < 0) ? '0 : (R'(1) << g);
                check("grant", req_ready, exp_oh);
                if (g < 0) g = 0;
                e.id       = IDW'(g);
                {e.q, e.r} = ref_div(req_dividend[g*N +: N], req_divisor[g*M +: M]);
                e.dz       = DZ_EN && (req_divisor[g*M +: M] == '0);
                sb.push_back(e);
                tb_ptr  = (g + 1) % R;
                acc_cyc = cyc;
                acc_id  = g;
                n_acc++;
            end
            if (rsp_valid && !prev_rv) begin
                rise_cyc = cyc;
                n_rise++;
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("sb_id", rsp_id, e.id);
                    check("sb_quot", rsp_quotient, e.q);
                    check("sb_rem", rsp_remainder, e.r);
                    check("sb_dz", rsp_divzero, e.dz);
                end
                hs_cyc = cyc;
                n_hs++;
            end
            prev_rv = rsp_valid;
        end
    end

    function automatic int cnt_of(input int which);
        case (which)
            0:       return n_acc;
            1:       return n_rise;
            2:       return n_hs;
            default: return n_start;
        endcase
    endfunction

    // Bounded wait for one of the monitor counters to reach a target.
    task automatic wait_cnt(input int which, input int target, input string tag);
        int k = 0;
        while (cnt_of(which) < target && k < 60) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (cnt_of(which) < target) check({tag, "_timeout"}, cnt_of(which), target);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic [N-1:0] a, input logic [M-1:0] b);
        req_dividend[i*N +: N] = a;
        req_divisor[i*M +: M]  = b;
        req_valid[i]           = 1'b1;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_div_start"}, div_start, 0);
        check({tag, "_div_ops"}, {div_dividend, div_divisor}, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_fields"}, {rsp_id, rsp_quotient, rsp_remainder, rsp_divzero}, 0);
        check({tag, "_state"}, dut.state_q, ST_IDLE);
        check({tag, "_rr_ptr"}, dut.rr_ptr_q, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2, s0;
        int ids[5];
        int cycs[5];
        reset        = 1'b1;
        rsp_ready    = 1'b1;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outs("rst");
        tick();
        reset = 1'b0;
        tick();

        // Single request from requester 2: 100 / 7
        t = n_acc + 1; t2 = n_rise + 1;
        drive(2, 8'd100, 4'd7);
        wait_cnt(0, t, "single_acc");
        tick();
        req_valid = '0;
        wait_cnt(1, t2, "single_rsp");
        check("single_lat", rise_cyc - acc_cyc, N + 3);
        check("single_rsp", {rsp_id, rsp_quotient, rsp_remainder, rsp_divzero}, {2'd2, 8'd14, 4'd2, 1'b0});
        wait_cnt(2, n_hs + 0, "single_hs");
        tick();

        // Signed operands from requester 0 (pointer wraps from 3)
        t = n_acc + 1; t2 = n_rise + 1;
        drive(0, 8'h9C, 4'd7);
        wait_cnt(0, t, "signed_acc");
        check("signed_id", acc_id, 0);
        tick();
        req_valid = '0;
        wait_cnt(1, t2, "signed_rsp");
        check("signed_const", {rsp_quotient, rsp_remainder}, {8'hF2, 4'hE});
        check("signed_model", {rsp_quotient, rsp_remainder}, ref_div(8'h9C, 4'd7));
        tick();

        // Backpressure: two pending requesters, response held for 20 cycles
        rsp_ready = 1'b0;
        t = n_acc + 1; t2 = n_rise + 1;
        drive(1, 8'd50, 4'd3);
        drive(3, 8'd127, 4'd7);
        wait_cnt(0, t, "bp_acc");
        check("bp_id", acc_id, 1);
        wait_cnt(1, t2, "bp_rsp");
        repeat (20) begin
            @(negedge clk);
            #1;
            check("bp_hold", {rsp_valid, req_ready, rsp_id, rsp_quotient, rsp_remainder},
                  {1'b1, 4'b0000, 2'd1, 8'd16, 4'd2});
        end
        tick();
        rsp_ready = 1'b1;
        wait_cnt(0, t + 1, "bp_next_acc");
        check("bp_next_id", acc_id, 3);
        check("bp_next_cyc", acc_cyc, hs_cyc + 1);
        tick();
        req_valid = '0;
        wait_cnt(2, n_hs + 1, "bp_drain");
        tick();

        // Reset three cycles after div_start, mid-WAIT
        t = n_acc + 1; s0 = n_start + 1;
        drive(1, 8'd77, 4'd5);
        wait_cnt(0, t, "rst_acc");
        tick();
        req_valid = '0;
        wait_cnt(3, s0, "rst_start");
        repeat (3) tick();
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_reset_outs("midrst");
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Fairness: all requesters valid, grants rotate from index 0
        t = n_acc;
        drive(0, 8'd50, 4'd3);
        drive(1, 8'hC8, 4'hB);
        drive(2, 8'd127, 4'd7);
        drive(3, 8'd9, 4'hF);
        for (int i = 0; i < 5; i++) begin
            wait_cnt(0, t + i + 1, "fair_acc");
            ids[i]  = acc_id;
            cycs[i] = acc_cyc;
        end
        tick();
        req_valid = '0;
        check("fair_order", {ids[0][3:0], ids[1][3:0], ids[2][3:0], ids[3][3:0], ids[4][3:0]},
              {4'd0, 4'd1, 4'd2, 4'd3, 4'd0});
        for (int i = 1; i < 5; i++) begin
            check("fair_gap", cycs[i] - cycs[i-1], N + 4);
        end
        wait_cnt(2, n_hs + 1, "fair_drain");
        tick();

        // Zero divisor from requester 2
        t = n_acc + 1; t2 = n_rise + 1; s0 = n_start;
        drive(2, 8'h5A, 4'd0);
        wait_cnt(0, t, "dz_acc");
        tick();
        req_valid = '0;
        wait_cnt(1, t2, "dz_rsp");
        check("dz_lat", rise_cyc - acc_cyc, DZ_LAT);
        check("dz_rsp", {rsp_id, rsp_quotient, rsp_remainder, rsp_divzero}, {2'd2, 8'hFF, 4'hA, DZ_EN});
        check("dz_starts", n_start - s0, DZ_STARTS);
        repeat (3) tick();

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
